mult8_seq_ctrl: RTL and testbench



---
 rtl/mult8_pkg.sv | 21 ++
 rtl/array_multiplier.sv | 19 +
 rtl/mult8_seq_ctrl.sv | 105 ++++++++++
 tb/tb_mult8_seq_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/mult8_pkg.sv
// rtl/mult8_pkg.sv - shared states, widths and step helpers for the 8x8 sequential multiplier
package mult8_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NUM_STEPS = 4;
    localparam int OPND_W    = 8;
    localparam int NIB_W     = 4;
    localparam int PROD_W    = 16;
    localparam int STEP_W    = $clog2(NUM_STEPS);

    // Step 0 -> 0, steps 1/2 -> 4, step 3 -> 8: the shift is NIB_W times the count of high nibbles used.
    function automatic logic [3:0] step_shift(input logic [STEP_W-1:0] step);
        return {step[1] & step[0], step[1] ^ step[0], 2'b00};
    endfunction

endpackage

// File: rtl/array_multiplier.sv
// rtl/array_multiplier.sv - combinational WxW unsigned array multiplier
module array_multiplier #(
    parameter int W = 4
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);

    always_comb begin
        p = '0;
        for (int i = 0; i < W; i++) begin
            if (b[i]) begin
                p = p + ({{W{1'b0}}, a} << i);
            end
        end
    end

endmodule

// File: rtl/mult8_seq_ctrl.sv
// rtl/mult8_seq_ctrl.sv - 8x8 multiply over four 4x4 steps; MULT8_ZERO_SKIP_EN enables zero-operand bypass
module mult8_seq_ctrl
    import mult8_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_a,
    input  logic [7:0]        in_b,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_p,
    output logic [TAG_W-1:0]  out_tag
);

    state_t                state;
    logic [STEP_W-1:0]     step;
    logic [OPND_W-1:0]     a_reg;
    logic [OPND_W-1:0]     b_reg;
    logic [TAG_W-1:0]      tag_reg;
    logic [PROD_W-1:0]     acc;

    logic [NIB_W-1:0]      nib_a;
    logic [NIB_W-1:0]      nib_b;
    logic [2*NIB_W-1:0]    pp;
    logic [PROD_W-1:0]     pp_shifted;
    logic                  skip;

    // Bit 0 of step selects the high multiplicand nibble, bit 1 the high multiplier nibble.
    assign nib_a      = step[0] ? a_reg[OPND_W-1:NIB_W] : a_reg[NIB_W-1:0];
    assign nib_b      = step[1] ? b_reg[OPND_W-1:NIB_W] : b_reg[NIB_W-1:0];
    assign pp_shifted = PROD_W'(pp) << step_shift(step);

    array_multiplier #(.W(NIB_W)) u_mult (
        .a (nib_a),
        .b (nib_b),
        .p (pp)
    );

`ifdef MULT8_ZERO_SKIP_EN
    assign skip = (in_a == '0) || (in_b == '0);
`else
    assign skip = 1'b0;
`endif

    assign out_p   = acc;
    assign out_tag = tag_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            step      <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            tag_reg   <= '0;
            acc       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg    <= in_a;
                        b_reg    <= in_b;
                        tag_reg  <= in_tag;
                        acc      <= '0;
                        step     <= '0;
                        in_ready <= 1'b0;
                        if (skip) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state <= MUL;
                        end
                    end
                end
                MUL: begin
                    acc  <= acc + pp_shifted;
                    step <= step + 1'b1;
                    if (step == STEP_W'(NUM_STEPS - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// tb/tb_mult8_seq_ctrl.sv - self-checking bench for mult8_seq_ctrl against an arithmetic reference
module tb_mult8_seq_ctrl;

    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_a = '0;
    logic [7:0]       in_b = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [15:0]      out_p;
    logic [TAG_W-1:0] out_tag;

    int total = 0;
    int bad   = 0;
    logic [TAG_W-1:0] tag_q[$];

    mult8_seq_ctrl #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    function automatic int ref_latency(input logic [7:0] a, input logic [7:0] b);
`ifdef MULT8_ZERO_SKIP_EN
        if (a == 8'd0 || b == 8'd0) return 1;
`endif
        return 5;
    endfunction

    // One full operation: launch, track latency, hold the result for 'stall' cycles, then accept it.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [TAG_W-1:0] tag, input int stall);
        int               n;
        logic [15:0]      exp_p;
        logic [TAG_W-1:0] exp_tag;
        exp_p = 16'(a) * 16'(b);
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_launch", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_tag    = tag;
        out_ready = (stall == 0);
        tag_q.push_back(tag);
        @(negedge clk);
        // Junk on the input while busy must be ignored.
        in_valid = 1'b1;
        in_a     = ~a;
        in_b     = 8'h5A;
        in_tag   = ~tag;
        n = 1;
        while (!out_valid && n < 20) begin
            check("in_ready_busy", 32'(in_ready), 32'd0);
            @(negedge clk);
            n++;
        end
        exp_tag = tag_q.pop_front();
        check("latency", 32'(n), 32'(ref_latency(a, b)));
        check("out_valid", 32'(out_valid), 32'd1);
        check("out_p", 32'(out_p), 32'(exp_p));
        check("out_tag", 32'(out_tag), 32'(exp_tag));
        check("in_ready_done", 32'(in_ready), 32'd0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_p", 32'(out_p), 32'(exp_p));
            check("stall_tag", 32'(out_tag), 32'(exp_tag));
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("valid_one_cycle", 32'(out_valid), 32'd0);
        check("in_ready_after", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        int         rs;

        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_p", 32'(out_p), 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(8'h12, 8'h34, 4'd3, 0);
        check("ex_12x34", 32'(out_p), 32'h03A8);
        run_op(8'hFF, 8'hFF, 4'd5, 0);
        run_op(8'hA5, 8'h3C, 4'd7, 10);
        run_op(8'h00, 8'hAB, 4'd1, 0);
        run_op(8'hAB, 8'h00, 4'd2, 2);
        run_op(8'h01, 8'h01, 4'd4, 0);

        // Abort mid-operation: reset in cycle T+2.
        in_valid = 1'b1;
        in_a     = 8'h12;
        in_b     = 8'h34;
        in_tag   = 4'd9;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_p", 32'(out_p), 32'd0);
        check("abort_out_tag", 32'(out_tag), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort_no_result", 32'(out_valid), 32'd0);
        end
        run_op(8'h0F, 8'h10, 4'd6, 0);

        for (int i = 0; i < 16; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = int'($urandom_range(0, 3));
            run_op(ra, rb, TAG_W'(i), rs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
